// File: rtl/moore_1101_gen.sv
// Serial pattern transmitter: latches a PAT_W-bit pattern on start and
// shifts it out MSB-first, repeating it rep times with GAP_CYC idle
// cycles between repetitions. The control FSM is one-hot and Moore-style.
// All outputs are flops loaded from the next-state values, so each output
// is a registered function of the state it belongs to.
module moore_1101_gen #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] rep,
  output logic             out,
  output logic             out_vld,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  // One-hot state bit positions and encodings
  localparam int S_IDLE  = 0;
  localparam int S_SHIFT = 1;
  localparam int S_GAP   = 2;
  localparam int S_DONE  = 3;

  localparam logic [3:0] IDLE  = 4'b0001;
  localparam logic [3:0] SHIFT = 4'b0010;
  localparam logic [3:0] GAP   = 4'b0100;
  localparam logic [3:0] DONE  = 4'b1000;

  logic [3:0]       state_reg,    state_next;
  logic [PAT_W-1:0] shreg_reg,    shreg_next;
  logic [PAT_W-1:0] pat_reg,      pat_next;
  logic [BIT_W-1:0] bit_cnt_reg,  bit_cnt_next;
  logic [CNT_W-1:0] rep_left_reg, rep_left_next;
  logic [GAP_W-1:0] gap_cnt_reg,  gap_cnt_next;

  logic out_reg,     out_next;
  logic out_vld_reg, out_vld_next;
  logic busy_reg,    busy_next;
  logic done_reg,    done_next;

  // State, datapath and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      pat_reg      <= '0;
      bit_cnt_reg  <= '0;
      rep_left_reg <= '0;
      gap_cnt_reg  <= '0;
      out_reg      <= 1'b0;
      out_vld_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      pat_reg      <= pat_next;
      bit_cnt_reg  <= bit_cnt_next;
      rep_left_reg <= rep_left_next;
      gap_cnt_reg  <= gap_cnt_next;
      out_reg      <= out_next;
      out_vld_reg  <= out_vld_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Next-state and datapath update; illegal encodings fall back to IDLE
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    pat_next      = pat_reg;
    bit_cnt_next  = bit_cnt_reg;
    rep_left_next = rep_left_reg;
    gap_cnt_next  = gap_cnt_reg;

    case (state_reg)
      IDLE: begin
        // A zero repetition count is a no-op request
        if (start && (rep != '0)) begin
          pat_next      = pat;
          shreg_next    = pat;
          bit_cnt_next  = BIT_LOAD;
          rep_left_next = rep;
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        shreg_next   = shreg_reg << 1;
        bit_cnt_next = bit_cnt_reg - BIT_ONE;
        if (bit_cnt_reg == '0) begin
          bit_cnt_next = '0;
          // Last repetition finished; <= also covers a corrupted zero count
          if (rep_left_reg <= REP_ONE) begin
            state_next = DONE;
          end else begin
            rep_left_next = rep_left_reg - REP_ONE;
            if (GAP_CYC > 0) begin
              gap_cnt_next = GAP_LOAD;
              state_next   = GAP;
            end else begin
              // Back-to-back repetitions: reload without a bubble
              shreg_next   = pat_reg;
              bit_cnt_next = BIT_LOAD;
            end
          end
        end
      end

      GAP: begin
        if (gap_cnt_reg == '0) begin
          shreg_next   = pat_reg;
          bit_cnt_next = BIT_LOAD;
          state_next   = SHIFT;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_ONE;
        end
      end

      DONE: begin
        // start is not looked at here; the first IDLE cycle can accept it
        state_next = IDLE;
      end

      default: begin
        state_next    = IDLE;
        shreg_next    = '0;
        bit_cnt_next  = '0;
        rep_left_next = '0;
        gap_cnt_next  = '0;
      end
    endcase
  end

  // Output values for the upcoming state, captured by the output flops
  always_comb begin
    out_next     = state_next[S_SHIFT] ? shreg_next[PAT_W-1] : 1'b0;
    out_vld_next = state_next[S_SHIFT];
    busy_next    = state_next[S_SHIFT] | state_next[S_GAP];
    done_next    = state_next[S_DONE];
  end

  assign out     = out_reg;
  assign out_vld = out_vld_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

  // IDLE has no dedicated output; its bit is only used by the encoding
  logic unused_idle;
  assign unused_idle = state_next[S_IDLE];

endmodule

// File: tb/tb_moore_1101_gen.sv
// Directed bench for moore_1101_gen: a vector table for the default
// configuration plus hand-written sequences for max repeat count and a
// GAP_CYC=0 instance. Expected outputs are packed as {out,out_vld,busy,done}.
module tb_moore_1101_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT (GAP_CYC=2)
  logic       rst, start;
  logic [3:0] pat, rep;
  logic       out, out_vld, busy, done;

  // Back-to-back DUT (GAP_CYC=0)
  logic       rst0, start0;
  logic [3:0] pat0, rep0;
  logic       out0, out_vld0, busy0, done0;

  moore_1101_gen dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .rep(rep),
    .out(out), .out_vld(out_vld), .busy(busy), .done(done)
  );

  moore_1101_gen #(.PAT_W(4), .CNT_W(4), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .pat(pat0), .rep(rep0),
    .out(out0), .out_vld(out_vld0), .busy(busy0), .done(done0)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] pat;
    logic [3:0] rep;
    logic [3:0] exp;
  } vec_t;

  localparam logic [3:0] E_IDLE = 4'b0000;
  localparam logic [3:0] E_HI   = 4'b1110;
  localparam logic [3:0] E_LO   = 4'b0110;
  localparam logic [3:0] E_GAP  = 4'b0010;
  localparam logic [3:0] E_DONE = 4'b0001;

  vec_t tab[64];
  int   n_tab = 0;
  int   n_vec = 0;
  int   n_err = 0;

  int         det = 0, det_base = 0, det0 = 0;
  logic [3:0] hist = 4'b0000, hist0 = 4'b0000;

  task automatic add(input logic r, input logic s, input logic [3:0] p,
                     input logic [3:0] q, input logic [3:0] e);
    tab[n_tab].rst   = r;
    tab[n_tab].start = s;
    tab[n_tab].pat   = p;
    tab[n_tab].rep   = q;
    tab[n_tab].exp   = e;
    n_tab++;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: out/vld/busy/done got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] s0;
    int busy_n, done_n, cyc;

    rst = 1'b1; start = 1'b0; pat = '0; rep = '0;
    rst0 = 1'b1; start0 = 1'b0; pat0 = '0; rep0 = '0;

    // Reset and idle
    add(1, 0, 4'h0, 4'h0, E_IDLE);   // 0
    add(0, 0, 4'h0, 4'h0, E_IDLE);   // 1
    // rep=1, pattern 1101
    add(0, 1, 4'hD, 4'h1, E_HI);     // 2
    add(0, 0, 4'hD, 4'h1, E_HI);     // 3
    add(0, 0, 4'hD, 4'h1, E_LO);     // 4
    add(0, 0, 4'hD, 4'h1, E_HI);     // 5
    add(0, 0, 4'hD, 4'h1, E_DONE);   // 6
    add(0, 0, 4'hD, 4'h1, E_IDLE);   // 7
    // rep=3 with starts and input changes during SHIFT, GAP and DONE
    add(0, 1, 4'hD, 4'h3, E_HI);     // 8
    add(0, 1, 4'h0, 4'h5, E_HI);     // 9
    add(0, 0, 4'h0, 4'h5, E_LO);     // 10
    add(0, 0, 4'h0, 4'h5, E_HI);     // 11
    add(0, 1, 4'hF, 4'h7, E_GAP);    // 12
    add(0, 0, 4'hF, 4'h7, E_GAP);    // 13
    add(0, 0, 4'hF, 4'h7, E_HI);     // 14
    add(0, 0, 4'hF, 4'h7, E_HI);     // 15
    add(0, 0, 4'hF, 4'h7, E_LO);     // 16
    add(0, 0, 4'hF, 4'h7, E_HI);     // 17
    add(0, 1, 4'h0, 4'h2, E_GAP);    // 18
    add(0, 0, 4'h0, 4'h2, E_GAP);    // 19
    add(0, 0, 4'h0, 4'h2, E_HI);     // 20
    add(0, 0, 4'h0, 4'h2, E_HI);     // 21
    add(0, 0, 4'h0, 4'h2, E_LO);     // 22
    add(0, 0, 4'h0, 4'h2, E_HI);     // 23
    add(0, 0, 4'h0, 4'h2, E_DONE);   // 24
    add(0, 1, 4'hD, 4'h3, E_IDLE);   // 25 start during DONE: ignored
    add(0, 0, 4'hD, 4'h3, E_IDLE);   // 26
    // rep=0 requests are ignored for 10 cycles
    for (int k = 0; k < 10; k++) add(0, 1, 4'hD, 4'h0, E_IDLE);  // 27..36
    // then pattern 1010, rep=1
    add(0, 1, 4'hA, 4'h1, E_HI);     // 37
    add(0, 0, 4'hA, 4'h1, E_LO);     // 38
    add(0, 0, 4'hA, 4'h1, E_HI);     // 39
    add(0, 0, 4'hA, 4'h1, E_LO);     // 40
    add(0, 0, 4'hA, 4'h1, E_DONE);   // 41
    add(0, 0, 4'hA, 4'h1, E_IDLE);   // 42
    // reset during the 2nd bit of a rep=3 stream, then a fresh start
    add(0, 1, 4'hD, 4'h3, E_HI);     // 43
    add(0, 0, 4'hD, 4'h3, E_HI);     // 44
    add(1, 0, 4'hD, 4'h3, E_IDLE);   // 45
    add(0, 0, 4'hD, 4'h3, E_IDLE);   // 46
    add(0, 1, 4'hD, 4'h1, E_HI);     // 47
    add(0, 0, 4'hD, 4'h1, E_HI);     // 48
    add(0, 0, 4'hD, 4'h1, E_LO);     // 49
    add(0, 0, 4'hD, 4'h1, E_HI);     // 50
    add(0, 0, 4'hD, 4'h1, E_DONE);   // 51
    add(0, 0, 4'hD, 4'h1, E_IDLE);   // 52

    for (int i = 0; i < n_tab; i++) begin
      @(negedge clk);
      rst   = tab[i].rst;
      start = tab[i].start;
      pat   = tab[i].pat;
      rep   = tab[i].rep;
      @(posedge clk);
      #1;
      $display("vec %0d rst=%b start=%b pat=%b rep=%0d -> out/vld/busy/done=%b",
               i, tab[i].rst, tab[i].start, tab[i].pat, tab[i].rep,
               {out, out_vld, busy, done});
      hist = {hist[2:0], out};
      if (hist == 4'b1101) det++;
      chk($sformatf("vec%0d", i), {out, out_vld, busy, done}, tab[i].exp);
      if (i == 7) det_base = det;
      if (i == 24) chk_int("det_rep3", det - det_base, 3);
    end

    // Maximum repeat count: 15*4 bits + 14*2 gap cycles of busy
    @(negedge clk);
    start = 1'b1; pat = 4'hD; rep = 4'hF;
    busy_n = 0; done_n = 0; cyc = 0;
    while (cyc < 200 && done_n == 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) busy_n++;
      if (done) done_n++;
      cyc++;
    end
    $display("rep15: busy cycles %0d, done seen %0d after %0d cycles", busy_n, done_n, cyc);
    chk_int("rep15_done_seen", done_n, 1);
    chk_int("rep15_busy_cycles", busy_n, 88);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rep15_after%0d", k), {out, out_vld, busy, done}, E_IDLE);
    end

    // GAP_CYC=0 instance: 11011101 contiguous, done on the 9th cycle
    @(posedge clk);
    #1;
    chk("gap0_reset", {out0, out_vld0, busy0, done0}, E_IDLE);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1; pat0 = 4'hD; rep0 = 4'h2;
    s0 = 8'b11011101;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      hist0 = {hist0[2:0], out0};
      if (hist0 == 4'b1101) det0++;
      $display("gap0 bit %0d -> out/vld/busy/done=%b", k, {out0, out_vld0, busy0, done0});
      chk($sformatf("gap0_bit%0d", k), {out0, out_vld0, busy0, done0},
          {s0[7-k], 3'b110});
    end
    @(posedge clk);
    #1;
    chk("gap0_done", {out0, out_vld0, busy0, done0}, E_DONE);
    @(posedge clk);
    #1;
    chk("gap0_idle", {out0, out_vld0, busy0, done0}, E_IDLE);
    chk_int("gap0_det", det0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
